// File: rtl/clm_output_reduce_pkg.sv
// Shared types for the CLM masked-AES output stage.
//
// Bit-order note: the algorithm is described with element bit 0 as the highest
// power of x. Here every vector is declared descending, so "bit 0" of an
// element is its most significant bit. In numeric terms:
//   state_t     : bit b = coefficient of x^b (bit ELEM_W-1 = x^(7+d))
//   base_poly_t : bit b = coefficient of x^b (bit 8 = x^8, must be 1)
//   residue     : top byte of a reduced element, bit b = x^b
//   mm_matrix_t : m[i][j], where i and j count from the MSB of the output and
//                 residue bytes (i = 0 is output bit 7, j = 0 is residue bit 7)
package clm_output_reduce_pkg;

  localparam int d            = 8;
  localparam int ELEM_W       = 8 + d;
  localparam int OUT_CNT_BITS = $clog2(d);

  typedef logic [ELEM_W-1:0]   state_t;
  typedef state_t [3:0][3:0]   state_vec_t;   // [row][col]
  typedef logic [8:0]          base_poly_t;
  typedef logic [7:0][7:0]     mm_matrix_t;

  typedef enum logic [1:0] {O_IDLE, O_REDUCE, O_MAP, O_DONE} out_stages_t;

  // Linv x residue over GF(2). Matrix indices count from the MSB, so row i
  // drives output bit 7-i and column j multiplies residue bit 7-j.
  function automatic logic [7:0] linv_mul(input mm_matrix_t m, input logic [7:0] r);
    logic [7:0] o;
    logic       acc;
    o = '0;
    for (int i = 0; i < 8; i++) begin
      acc = 1'b0;
      for (int j = 0; j < 8; j++) begin
        acc = acc ^ (m[i][j] & r[7-j]);
      end
      o[7-i] = acc;
    end
    return o;
  endfunction

endpackage

// File: rtl/clm_mod_p_step.sv
// One bit-serial reduction step on a single redundant element.
// If the top coefficient is set, P is folded into the top nine bits, which
// clears that coefficient (P's x^8 bit is 1); the element is then shifted up by
// one with a zero entering at the bottom. d such steps leave the residue
// mod P in the top byte.
// Ports:
//   e      : element before the step
//   p      : base polynomial (bit 8 = x^8)
//   e_next : element after fold-and-shift
module clm_mod_p_step
  import clm_output_reduce_pkg::*;
(
  input  state_t     e,
  input  base_poly_t p,
  output state_t     e_next
);

  state_t folded;

  always_comb begin
    folded = e;
    if (e[ELEM_W-1]) begin
      folded[ELEM_W-1 -: 9] = e[ELEM_W-1 -: 9] ^ p;
    end
    e_next = folded << 1;
  end

endmodule

// File: rtl/clm_output_reduce.sv
// CLM masked-AES output stage: reduces all 16 redundant elements modulo P
// bit-serially (d cycles), maps each residue through Linv back to a standard
// AES byte, and packs the ciphertext.
//
// Build option: define CLM_OUT_ZEROIZE_EN to wipe the working elements and the
// captured P/Linv when leaving O_DONE. Port timing is the same either way.
//
// Ports:
//   clk, rst   : clock; asynchronous active-high reset
//   drdy_i     : start strobe, only sampled while idle
//   in         : redundant state [row][col]
//   P          : base polynomial
//   Linv       : inverse basis map
//   ciphertext : packed result; byte k = state[k%4][k/4], byte 0 is the MSB byte
//   drdy_o     : one-cycle pulse, ciphertext valid
//   busy       : high whenever not idle
//
// Handshake: drdy_i is a single-cycle strobe with no back-pressure; it is
// accepted only in O_IDLE and dropped otherwise. drdy_o is a single-cycle
// pulse in O_DONE; ciphertext stays stable from then until the next O_MAP.
module clm_output_reduce
  import clm_output_reduce_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         drdy_i,
  input  state_vec_t   in,
  input  base_poly_t   P,
  input  mm_matrix_t   Linv,
  output logic [127:0] ciphertext,
  output logic         drdy_o,
  output logic         busy
);

  out_stages_t state, state_d;

  state_vec_t              work_q;
  state_vec_t              work_step;
  base_poly_t              p_q;
  mm_matrix_t              linv_q;
  logic [OUT_CNT_BITS-1:0] cnt_q;
  logic [127:0]            ct_next;

  logic capture;
  logic step;
  logic load_ct;
`ifdef CLM_OUT_ZEROIZE_EN
  logic clear_work;
`endif

  // Per-element reduce-and-shift, all 16 in parallel.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      clm_mod_p_step u_step (
        .e      (work_q[r][c]),
        .p      (p_q),
        .e_next (work_step[r][c])
      );
    end
  end

  // Residue sits in the top byte of each element once reduction is done.
  always_comb begin
    ct_next = '0;
    for (int k = 0; k < 16; k++) begin
      ct_next[127 - 8*k -: 8] = linv_mul(linv_q, work_q[k % 4][k / 4][ELEM_W-1 -: 8]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= O_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    capture = 1'b0;
    step    = 1'b0;
    load_ct = 1'b0;
`ifdef CLM_OUT_ZEROIZE_EN
    clear_work = 1'b0;
`endif
    case (state)
      O_IDLE: begin
        if (drdy_i) begin
          capture = 1'b1;
          state_d = O_REDUCE;
        end
      end
      O_REDUCE: begin
        step = 1'b1;
        if (cnt_q == OUT_CNT_BITS'(d - 1)) begin
          state_d = O_MAP;
        end
      end
      O_MAP: begin
        load_ct = 1'b1;
        state_d = O_DONE;
      end
      O_DONE: begin
`ifdef CLM_OUT_ZEROIZE_EN
        clear_work = 1'b1;
`endif
        state_d = O_IDLE;
      end
      default: state_d = O_IDLE;
    endcase
  end

  assign drdy_o = (state == O_DONE);
  assign busy   = (state != O_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q <= '0;
      p_q    <= '0;
      linv_q <= '0;
      cnt_q  <= '0;
    end else if (capture) begin
      work_q <= in;
      p_q    <= P;
      linv_q <= Linv;
      cnt_q  <= '0;
    end else if (step) begin
      work_q <= work_step;
      cnt_q  <= cnt_q + OUT_CNT_BITS'(1);
`ifdef CLM_OUT_ZEROIZE_EN
    end else if (clear_work) begin
      work_q <= '0;
      p_q    <= '0;
      linv_q <= '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ciphertext <= '0;
    end else if (load_ct) begin
      ciphertext <= ct_next;
    end
  end

endmodule
